// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready producers.
// The winning word is staged one cycle; a credit counter keeps the FIFO from overflowing.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    i_req_data,
  output logic [NUM_REQ-1:0]           o_req_ready,
  input  logic                         i_fifo_rd_en,
  output logic                         o_fifo_wr_en,
  output logic [DATA_W-1:0]            o_fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0]   o_wr_src,
  output logic [LVL_W-1:0]             o_level,
  output logic                         o_full
);

  localparam int                SRC_W    = $clog2(NUM_REQ);
  localparam logic [LVL_W-1:0]  DEPTH_L  = LVL_W'(FIFO_DEPTH);
  localparam logic [SRC_W-1:0]  LAST_SRC = SRC_W'(NUM_REQ - 1);

  logic [SRC_W-1:0]   r_rr_ptr;
  logic [LVL_W-1:0]   r_level;
  logic               r_wr_en;
  logic [DATA_W-1:0]  r_wr_data;
  logic [SRC_W-1:0]   r_wr_src;

  logic               w_found;
  logic [SRC_W-1:0]   w_winner;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_accept;
  logic [LVL_W-1:0]   w_stored;
  logic               w_dec;
  logic [LVL_W-1:0]   w_level_nxt;
  logic [SRC_W-1:0]   w_ptr_nxt;
  logic [DATA_W-1:0]  w_win_data;

  // Rotating-priority scan: first valid producer at or after r_rr_ptr, wrapping.
  always_comb begin
    int idx;
    w_found  = 1'b0;
    w_winner = r_rr_ptr;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end else begin
        idx = idx;
      end
      if (!w_found && i_req_valid[idx]) begin
        w_found  = 1'b1;
        w_winner = SRC_W'(idx);
      end else begin
        w_found  = w_found;
      end
    end
  end

  // Ready is driven from the registered level only, so a freed slot is grantable next cycle.
  always_comb begin
    w_ready = '0;
    if (i_rst_n && w_found && (r_level < DEPTH_L)) begin
      w_ready[w_winner] = 1'b1;
    end else begin
      w_ready = '0;
    end
  end

  assign w_accept   = |(w_ready & i_req_valid);
  assign w_win_data = i_req_data[int'(w_winner)*DATA_W +: DATA_W];
  // The staged word is credited but not yet in the FIFO, so it cannot be read out.
  assign w_stored   = r_level - LVL_W'(r_wr_en);
  assign w_dec      = i_fifo_rd_en & (w_stored != '0);

  // Next credit level and next round-robin pointer.
  always_comb begin
    case ({w_accept, w_dec})
      2'b10:   w_level_nxt = r_level + LVL_W'(1);
      2'b01:   w_level_nxt = r_level - LVL_W'(1);
      default: w_level_nxt = r_level;
    endcase
    if (w_accept) begin
      w_ptr_nxt = (w_winner == LAST_SRC) ? '0 : w_winner + SRC_W'(1);
    end else begin
      w_ptr_nxt = r_rr_ptr;
    end
  end

  // State: pointer, credit level and the registered write stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_ptr  <= '0;
      r_level   <= '0;
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
      r_wr_src  <= '0;
    end else begin
      r_rr_ptr  <= w_ptr_nxt;
      r_level   <= w_level_nxt;
      r_wr_en   <= w_accept;
      if (w_accept) begin
        r_wr_data <= w_win_data;
        r_wr_src  <= w_winner;
      end
    end
  end

  assign o_req_ready    = w_ready;
  assign o_fifo_wr_en   = r_wr_en;
  assign o_fifo_wr_data = r_wr_data;
  assign o_wr_src       = r_wr_src;
  assign o_level        = r_level;
  assign o_full         = (r_level == DEPTH_L);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a queue-free occupancy/priority model checked every
// negedge, plus hand-computed literal expectations for each scenario.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int D = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rd_en;
  logic           wr_en;
  logic [W-1:0]   wr_data;
  logic [1:0]     wr_src;
  logic [4:0]     level;
  logic           full;

  int n_tests = 0;
  int n_fail  = 0;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(W), .FIFO_DEPTH(D), .LVL_W(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .i_fifo_rd_en(rd_en), .o_fifo_wr_en(wr_en),
    .o_fifo_wr_data(wr_data), .o_wr_src(wr_src), .o_level(level), .o_full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: occupancy count, priority pointer, last written word.
  int         m_level, m_ptr, m_wr_src, m_win, m_k, m_stored;
  bit         m_wr_en, m_found, m_acc, m_dec;
  logic [7:0] m_wr_data;
  logic [3:0] m_rdy;
  logic [N-1:0]   prev_valid, prev_ready;
  logic [N*W-1:0] prev_data;
  logic [11:0]    wr_log[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_level = 0; m_ptr = 0; m_wr_en = 0; m_wr_data = 8'h00; m_wr_src = 0;
      prev_valid = '0; prev_ready = '0; prev_data = '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (prev_valid[k] && !prev_ready[k]) begin
          chk("producer_hold_valid", {31'd0, req_valid[k]}, 32'd1);
          chk("producer_hold_data", {24'd0, req_data[k*W +: W]}, {24'd0, prev_data[k*W +: W]});
        end
      end
    end
    m_found = 0; m_win = 0;
    for (int i = 0; i < N; i++) begin
      m_k = (m_ptr + i) % N;
      if (!m_found && req_valid[m_k]) begin m_found = 1; m_win = m_k; end
    end
    m_rdy = 4'b0000;
    if (rst_n && m_found && m_level < D) m_rdy[m_win] = 1'b1;

    chk("ready",   {28'd0, req_ready}, {28'd0, m_rdy});
    chk("level",   {27'd0, level}, m_level);
    chk("full",    {31'd0, full}, (m_level == D) ? 32'd1 : 32'd0);
    chk("wr_en",   {31'd0, wr_en}, {31'd0, m_wr_en});
    chk("wr_data", {24'd0, wr_data}, {24'd0, m_wr_data});
    chk("wr_src",  {30'd0, wr_src}, m_wr_src);
    if (wr_en) wr_log.push_back({2'b00, wr_src, wr_data});

    if (rst_n) begin
      prev_valid = req_valid; prev_ready = req_ready; prev_data = req_data;
      m_acc    = (m_rdy != 4'b0000);
      m_stored = m_level - (m_wr_en ? 1 : 0);
      m_dec    = rd_en && (m_stored > 0);
      m_level  = m_level + (m_acc ? 1 : 0) - (m_dec ? 1 : 0);
      m_wr_en  = m_acc;
      if (m_acc) begin
        m_wr_data = req_data[m_win*W +: W];
        m_wr_src  = m_win;
        m_ptr     = (m_win + 1) % N;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int k, input logic [7:0] v);
    req_data[k*W +: W] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rd_en = 1'b0; req_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] log_at(input int i);
    if (i < wr_log.size()) return {20'd0, wr_log[i]};
    return 32'hFFFF_FFFF;
  endfunction

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; rd_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    // Reset asserted between edges with requests pending
    #2;
    rst_n = 1'b0; req_valid = 4'b1111;
    #1;
    chk("rst_ready", {28'd0, req_ready}, 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    tick();
    tick();
    req_valid = '0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_level", {27'd0, level}, 32'd0);
    chk("idle_wr_en", {31'd0, wr_en}, 32'd0);

    // Single producer 2, three words back to back
    do_reset();
    wr_log.delete();
    req_valid = 4'b0100; set_data(2, 8'h05);
    #1 chk("sp_ready0", {28'd0, req_ready}, 32'h4);
    tick(); set_data(2, 8'h06);
    #1 chk("sp_ready1", {28'd0, req_ready}, 32'h4);
    tick(); set_data(2, 8'h07);
    #1 chk("sp_ready2", {28'd0, req_ready}, 32'h4);
    tick(); req_valid = '0;
    tick(); tick();
    chk("sp_level", {27'd0, level}, 32'd3);
    chk("sp_cnt", wr_log.size(), 32'd3);
    chk("sp_w0", log_at(0), 32'h205);
    chk("sp_w1", log_at(1), 32'h206);
    chk("sp_w2", log_at(2), 32'h207);

    // All four producers continuously valid until the FIFO fills
    do_reset();
    wr_log.delete();
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) set_data(k, 8'h10 + 8'(k));
    repeat (20) tick();
    chk("rr_level", {27'd0, level}, 32'd16);
    chk("rr_full", {31'd0, full}, 32'd1);
    chk("rr_ready", {28'd0, req_ready}, 32'd0);
    chk("rr_cnt", wr_log.size(), 32'd16);
    for (int i = 0; i < 16; i++)
      chk("rr_order", log_at(i), 32'(((i % 4) << 8) | (8'h10 + (i % 4))));
    rd_en = 1'b1;
    #1 chk("rr_rd_same_cycle", {28'd0, req_ready}, 32'd0);
    tick(); rd_en = 1'b0;
    #1 chk("rr_rd_level", {27'd0, level}, 32'd15);
    chk("rr_ptr_held", {28'd0, req_ready}, 32'h1);
    tick();
    chk("rr_refill_level", {27'd0, level}, 32'd16);
    chk("rr_refill_src", {30'd0, wr_src}, 32'd0);

    // Producer 1 alone fills the FIFO, then reads free slots
    do_reset();
    req_valid = 4'b0010; set_data(1, 8'h00);
    for (int i = 0; i < 16; i++) begin
      tick(); set_data(1, 8'(i + 1));
    end
    tick();
    chk("full_level", {27'd0, level}, 32'd16);
    rd_en = 1'b1;
    #1 chk("full_rd_no_pass", {28'd0, req_ready}, 32'd0);
    tick();
    #1 chk("full_after_rd", {27'd0, level}, 32'd15);
    chk("full_ready_next", {28'd0, req_ready}, 32'h2);
    tick(); rd_en = 1'b0;
    chk("acc_and_rd", {27'd0, level}, 32'd15);
    tick(); req_valid = '0;
    chk("refull", {27'd0, level}, 32'd16);

    // Reads of an empty FIFO, and of a FIFO holding only the staged word
    do_reset();
    rd_en = 1'b1;
    repeat (3) begin
      tick();
      chk("empty_rd", {27'd0, level}, 32'd0);
    end
    rd_en = 1'b0; req_valid = 4'b1000; set_data(3, 8'hA5);
    tick(); req_valid = '0; rd_en = 1'b1;
    chk("staged_level", {27'd0, level}, 32'd1);
    chk("staged_wr", {31'd0, wr_en}, 32'd1);
    tick();
    chk("staged_no_dec", {27'd0, level}, 32'd1);
    tick(); rd_en = 1'b0;
    chk("stored_dec", {27'd0, level}, 32'd0);

    // Reset in the middle of a burst
    do_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < N; k++) set_data(k, 8'h30 + 8'(k));
    tick(); req_valid = 4'b1110;
    repeat (8) tick();
    chk("burst_level", {27'd0, level}, 32'd9);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("mid_rst_level", {27'd0, level}, 32'd0);
    chk("mid_rst_ready", {28'd0, req_ready}, 32'd0);
    chk("mid_rst_data", {24'd0, wr_data}, 32'd0);
    tick(); tick();
    rst_n = 1'b1; req_valid = 4'b1001;
    #1 chk("post_rst_grant", {28'd0, req_ready}, 32'h1);
    tick(); req_valid = 4'b1000;
    chk("post_rst_src", {30'd0, wr_src}, 32'd0);
    chk("post_rst_data", {24'd0, wr_data}, 32'h30);
    tick(); req_valid = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
